// File: rtl/rs485_tx_de.sv
`default_nettype none
// ============================================================================
//  Module      : rs485_tx_de
//  Description : Half-duplex RS-485 8N1 UART transmitter with driver-enable
//                lead/tail guard sequencing. Bytes arrive on a valid/ready
//                handshake and leave LSB first on TxD, framed by DE.
//  Revision    : 1.0  initial release
// ============================================================================
module rs485_tx_de #(
  parameter int CLK_DIV = 16,  // clk cycles per bit, 2..65535
  parameter int DE_LEAD = 2,   // DE-high idle cycles before the start bit
  parameter int DE_TAIL = 2    // DE-high idle cycles after the stop bit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       DE,
  output logic       busy,
  output logic       tx_done
);

  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [7:0]    LEAD_LAST = 8'((DE_LEAD > 0) ? DE_LEAD - 1 : 0);
  localparam logic [7:0]    TAIL_LAST = 8'((DE_TAIL > 0) ? DE_TAIL - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_TAIL  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;   // position inside the current bit
  logic [7:0]    guard_q, guard_d;       // shared LEAD / TAIL guard counter
  logic [2:0]    bit_idx_q, bit_idx_d;   // data bit 0..7
  logic [7:0]    shreg_q, shreg_d;       // byte being shifted out, LSB on TxD
  logic          txd_q, txd_d;
  logic          de_q, de_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;

  // A byte can be taken while idle or while the previous frame's tail runs.
  assign tx_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_TAIL));
  assign accept   = tx_valid & tx_ready;

  // Next-state sequencing, then outputs derived from the state being entered
  // so that every pin except tx_ready comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    guard_d   = guard_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d   = tx_data;
          bit_cnt_d = '0;
          guard_d   = '0;
          state_d   = (DE_LEAD == 0) ? ST_START : ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (guard_q == LEAD_LAST) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      ST_START: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          guard_d   = '0;
          state_d   = (DE_TAIL == 0) ? ST_IDLE : ST_TAIL;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_TAIL: begin
        // A new byte here skips LEAD: DE is already up and the line is idle.
        if (accept) begin
          shreg_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end else if (guard_q == TAIL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    txd_d = 1'b1;
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shreg_d[0];
      default:  txd_d = 1'b1;
    endcase
    de_d   = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (bit_cnt_d == BIT_LAST);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      guard_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
      de_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      guard_q   <= guard_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
      de_q      <= de_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TxD     = txd_q;
  assign DE      = de_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rs485_tx_de.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rs485_tx_de
//  Description : Self-checking bench for rs485_tx_de. Three instances:
//                A (div 4, lead 2, tail 3), B (div 2, no guards),
//                C (div 65535, lead 2, tail 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs485_tx_de;

  localparam int DIV_A = 4, LEAD_A = 2, TAIL_A = 3;
  localparam int DIV_B = 2, LEAD_B = 0, TAIL_B = 0;
  localparam logic [3:0] IDLE_E = 4'b0010;  // {tail, done, txd, de}

  logic       clk = 1'b0;
  logic [2:0] rst, tx_valid, tx_ready, txd, de, busy, tx_done;
  logic [7:0] tx_data [3];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt [2];
  int de_low_cnt [2];
  bit mon_en = 1'b0;

  logic [3:0] q [2][$];
  logic [3:0] cur [2];

  always #5 clk = ~clk;

  rs485_tx_de #(.CLK_DIV(DIV_A), .DE_LEAD(LEAD_A), .DE_TAIL(TAIL_A)) u_a (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .TxD(txd[0]), .DE(de[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  rs485_tx_de #(.CLK_DIV(DIV_B), .DE_LEAD(LEAD_B), .DE_TAIL(TAIL_B)) u_b (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .TxD(txd[1]), .DE(de[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  rs485_tx_de #(.CLK_DIV(65535), .DE_LEAD(2), .DE_TAIL(2)) u_c (
    .clk(clk), .rst(rst[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .TxD(txd[2]), .DE(de[2]), .busy(busy[2]), .tx_done(tx_done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for A and B: on every accept the whole frame is laid out
  // cycle by cycle in a queue (lead, 10 bit slots, tail); an empty queue is idle.
  always @(negedge clk) begin : model
    logic [3:0] e;
    logic       exp_rdy;
    logic       bitv;
    string      t;
    if (mon_en) begin
      for (int u = 0; u < 2; u++) begin
        int dv, ld, tl;
        dv = (u == 0) ? DIV_A : DIV_B;
        ld = (u == 0) ? LEAD_A : LEAD_B;
        tl = (u == 0) ? TAIL_A : TAIL_B;
        t  = (u == 0) ? "A" : "B";
        e  = cur[u];
        exp_rdy = !rst[u] && ((e == IDLE_E) || e[3]);
        check({t, " DE"},       32'(de[u]),       32'(e[0]));
        check({t, " TxD"},      32'(txd[u]),      32'(e[1]));
        check({t, " tx_done"},  32'(tx_done[u]),  32'(e[2]));
        check({t, " busy"},     32'(busy[u]),     32'(e[0]));
        check({t, " tx_ready"}, 32'(tx_ready[u]), 32'(exp_rdy));
        if (!de[u]) de_low_cnt[u]++;
        if (tx_done[u]) done_cnt[u]++;
        if (rst[u]) begin
          q[u].delete();
          cur[u] = IDLE_E;
        end else begin
          if (tx_valid[u] && exp_rdy) begin
            q[u].delete();
            if (!e[3]) for (int k = 0; k < ld; k++) q[u].push_back(4'b0011);
            for (int i = 0; i < 10; i++) begin
              bitv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : tx_data[u][i-1];
              for (int c = 0; c < dv; c++)
                q[u].push_back({1'b0, (i == 9) && (c == dv - 1), bitv, 1'b1});
            end
            for (int k = 0; k < tl; k++) q[u].push_back(4'b1011);
          end
          cur[u] = (q[u].size() > 0) ? q[u].pop_front() : IDLE_E;
        end
      end
    end
  end

  // Present a byte and hold it until taken; returns at 1ns past the accept edge.
  task automatic send(input int u, input logic [7:0] b, output int waited);
    tx_data[u]  = b;
    tx_valid[u] = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (tx_ready[u]) break;
      waited++;
      if (waited > 200000) begin
        check("send timeout", 32'(waited), 0);
        break;
      end
    end
    @(posedge clk); #1;
    tx_valid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[u] && n < 3000);
    check("idle timeout", 32'(busy[u]), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int u, input int iters);
    int w;
    for (int it = 0; it < iters; it++) begin
      repeat ($urandom_range(0, 8)) @(posedge clk);
      #1;
      send(u, 8'($urandom), w);
      case ($urandom_range(0, 5))
        0: begin
          repeat ($urandom_range(0, 40)) @(posedge clk);
          #1; rst[u] = 1'b1;
          @(posedge clk); #1; rst[u] = 1'b0;
        end
        1, 2: ;
        default: wait_idle(u);
      endcase
    end
    wait_idle(u);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = '1;
    tx_valid = '0;
    for (int u = 0; u < 3; u++) tx_data[u] = 8'h00;
    for (int u = 0; u < 2; u++) begin
      cur[u] = IDLE_E; done_cnt[u] = 0; de_low_cnt[u] = 0;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("reset TxD",      32'(txd[u]),      1);
      check("reset DE",       32'(de[u]),       0);
      check("reset busy",     32'(busy[u]),     0);
      check("reset tx_done",  32'(tx_done[u]),  0);
      check("reset tx_ready", 32'(tx_ready[u]), 0);
    end
    @(posedge clk); #1;
    rst = '0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) check("ready after reset", 32'(tx_ready[u]), 1);
    @(posedge clk); #1;

    fork
      begin : branch_a
        int w, w2, bad, de_hi, done_at, snap_d, snap_l;
        logic [7:0] pat;
        logic       exp_t;
        // single frame 0xA5
        pat = 8'hA5; bad = 0; de_hi = 0; done_at = -1;
        send(0, pat, w);
        for (int k = 1; k <= 46; k++) begin
          @(negedge clk);
          if (k <= 2)       exp_t = 1'b1;
          else if (k <= 6)  exp_t = 1'b0;
          else if (k <= 38) exp_t = pat[(k - 7) / 4];
          else              exp_t = 1'b1;
          if (txd[0] !== exp_t) bad++;
          if (k <= 45 && de[0]) de_hi++;
          if (tx_done[0] && done_at < 0) done_at = k;
          if (k == 46) begin
            check("A5 DE low at 46",   32'(de[0]),   0);
            check("A5 busy low at 46", 32'(busy[0]), 0);
          end
        end
        check("A5 TxD pattern errors", 32'(bad),   0);
        check("A5 DE high cycles",     32'(de_hi), 45);
        check("A5 tx_done cycle",      32'(done_at), 42);
        repeat (3) @(posedge clk);
        #1;
        // back-to-back 0x00 then 0xFF, second held valid
        snap_d = done_cnt[0];
        send(0, 8'h00, w);
        snap_l = de_low_cnt[0];
        send(0, 8'hFF, w2);
        check("b2b accept cycle", 32'(w2 + 1), 43);
        @(negedge clk);
        check("b2b start bit", 32'(txd[0]), 0);
        check("b2b DE never low", 32'(de_low_cnt[0] - snap_l), 0);
        wait_idle(0);
        check("b2b tx_done pulses", 32'(done_cnt[0] - snap_d), 2);
        // handshake: data churns every cycle with valid held
        for (int i = 0; i < 150; i++) begin
          tx_data[0]  = 8'($urandom);
          tx_valid[0] = 1'b1;
          @(posedge clk); #1;
        end
        tx_valid[0] = 1'b0;
        wait_idle(0);
        // reset during data bit 3
        send(0, 8'($urandom), w);
        repeat (19) @(posedge clk);
        #1;
        snap_d = done_cnt[0];
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst ready low", 32'(tx_ready[0]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst TxD",   32'(txd[0]),      1);
        check("rst DE",    32'(de[0]),       0);
        check("rst ready", 32'(tx_ready[0]), 0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst no tx_done", 32'(done_cnt[0] - snap_d), 0);
        send(0, 8'h3C, w);
        wait_idle(0);
        check("3C one tx_done", 32'(done_cnt[0] - snap_d), 1);
        // valid together with reset: reset wins
        rst[0] = 1'b1; tx_valid[0] = 1'b1; tx_data[0] = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; tx_valid[0] = 1'b0;
        @(negedge clk);
        check("rst+valid no accept", 32'(busy[0]), 0);
        @(posedge clk); #1;
        rand_run(0, 40);
      end
      begin : branch_b
        int w, w2, done_at, low_at, snap_l;
        send(1, 8'h81, w);
        done_at = -1; low_at = -1;
        for (int k = 1; k <= 21; k++) begin
          @(negedge clk);
          if (k == 1) begin
            check("B start bit at 1", 32'(txd[1]), 0);
            check("B DE at 1",        32'(de[1]),  1);
          end
          if (tx_done[1] && done_at < 0) done_at = k;
          if (!de[1] && low_at < 0) low_at = k;
        end
        check("B stop end cycle", 32'(done_at), 20);
        check("B DE fall cycle",  32'(low_at),  21);
        @(posedge clk); #1;
        send(1, 8'h12, w);
        snap_l = de_low_cnt[1];
        send(1, 8'h34, w2);
        check("B b2b accept cycle", 32'(w2 + 1), 21);
        check("B b2b DE drop", 32'(de_low_cnt[1] - snap_l), 1);
        wait_idle(1);
        rand_run(1, 40);
      end
      begin : branch_c
        int w, n, lowc;
        send(2, 8'h55, w);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (txd[2] && n < 50);
        check("long start seen", 32'(txd[2]), 0);
        lowc = 0;
        while (!txd[2] && lowc < 70000) begin
          lowc++;
          @(negedge clk);
        end
        check("long start slot", 32'(lowc), 65535);
        check("long DE", 32'(de[2]), 1);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("long rst TxD", 32'(txd[2]), 1);
        check("long rst DE",  32'(de[2]),  0);
        @(posedge clk); #1;
        rst[2] = 1'b0;
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
